// File: rtl/long_to_double_if.sv
// long_to_double_if
//   Groups the operand and result stb/ack streams of long_to_double.
//   input_a/input_a_stb/input_a_ack : 64-bit signed operand channel
//   output_z/output_z_stb/output_z_ack : 64-bit IEEE-754 double result channel
//   master : the environment side (drives operand, accepts result)
//   slave  : the converter side
interface long_to_double_if;
    logic [63:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [63:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    modport master (
        output input_a, input_a_stb, output_z_ack,
        input  input_a_ack, output_z, output_z_stb
    );

    modport slave (
        input  input_a, input_a_stb, output_z_ack,
        output input_a_ack, output_z, output_z_stb
    );
endinterface

// File: rtl/long_to_double.sv
// long_to_double
//   Iterative int64 -> IEEE-754 double converter, round to nearest, ties to
//   even. One conversion in flight; operand and result use stb/ack streams.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : long_to_double_if.slave (input_a/_stb/_ack, output_z/_stb/_ack)
module long_to_double (
    input  logic              clk,
    input  logic              rst,
    long_to_double_if.slave   bus
);
    typedef enum logic [2:0] {
        GET_A, CONVERT_0, NORMALISE, ROUND, PACK, PUT_Z
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] a_q, a_d;
    logic [63:0] value_q, value_d;
    logic [10:0] exponent_q, exponent_d;
    logic        sign_q, sign_d;
    logic [51:0] frac_q, frac_d;
    logic [63:0] z_q, z_d;
    logic        ack_q, ack_d;
    logic        stb_q, stb_d;

    logic        round_up;
    logic        round_carry;

    assign bus.input_a_ack  = ack_q;
    assign bus.output_z     = z_q;
    assign bus.output_z_stb = stb_q;

    // Guard bit set and either sticky bits or an odd LSB: round up.
    assign round_up    = value_q[10] & ((|value_q[9:0]) | value_q[11]);
    // Increment of an all-ones 53-bit mantissa overflows to the next binade.
    assign round_carry = round_up & (&value_q[63:11]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= GET_A;
            a_q        <= '0;
            value_q    <= '0;
            exponent_q <= '0;
            sign_q     <= 1'b0;
            frac_q     <= '0;
            z_q        <= '0;
            ack_q      <= 1'b0;
            stb_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            value_q    <= value_d;
            exponent_q <= exponent_d;
            sign_q     <= sign_d;
            frac_q     <= frac_d;
            z_q        <= z_d;
            ack_q      <= ack_d;
            stb_q      <= stb_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        value_d    = value_q;
        exponent_d = exponent_q;
        sign_d     = sign_q;
        frac_d     = frac_q;
        z_d        = z_q;
        ack_d      = ack_q;
        stb_d      = stb_q;

        case (state_q)
            GET_A: begin
                ack_d = 1'b1;
                if (bus.input_a_stb && ack_q) begin
                    ack_d   = 1'b0;
                    a_d     = bus.input_a;
                    state_d = CONVERT_0;
                end
            end
            CONVERT_0: begin
                sign_d     = a_q[63];
                // -2^63 negates to itself, which is the right unsigned magnitude.
                value_d    = a_q[63] ? (~a_q + 64'd1) : a_q;
                exponent_d = 11'd63;
                if (a_q == 64'd0) begin
                    z_d     = '0;
                    state_d = PUT_Z;
                end else begin
                    state_d = NORMALISE;
                end
            end
            NORMALISE: begin
                if (!value_q[63]) begin
                    value_d    = value_q << 1;
                    exponent_d = exponent_q - 11'd1;
                end else begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                // Hidden bit is value_q[63]; a carry wraps the 52-bit fraction
                // to zero, which is exactly the 1<<52 mantissa of the next binade.
                frac_d = value_q[62:11] + {51'd0, round_up};
                if (round_carry)
                    exponent_d = exponent_q + 11'd1;
                state_d = PACK;
            end
            PACK: begin
                z_d     = {sign_q, exponent_q + 11'd1023, frac_q};
                stb_d   = 1'b1;
                state_d = PUT_Z;
            end
            PUT_Z: begin
                // The zero path arrives with stb low; it is raised here.
                stb_d = 1'b1;
                if (stb_q && bus.output_z_ack) begin
                    stb_d   = 1'b0;
                    state_d = GET_A;
                end
            end
            default: state_d = GET_A;
        endcase
    end
endmodule

// File: tb/tb_long_to_double.sv
module tb_long_to_double;
    logic clk = 1'b0;
    logic rst;

    long_to_double_if bus ();

    long_to_double dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Reference: the language's own signed-integer to double conversion.
    function automatic logic [63:0] ref_model(input logic [63:0] a);
        longint s;
        real    r;
        s = a;
        r = s;
        return $realtobits(r);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vecs++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Present an operand after 'gap' idle cycles; returns just after the accepting edge.
    task automatic send(input logic [63:0] a, input int gap);
        int n;
        @(negedge clk);
        repeat (gap) @(negedge clk);
        bus.input_a     = a;
        bus.input_a_stb = 1'b1;
        n = 0;
        while (bus.input_a_ack !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("ack_timeout", {63'd0, bus.input_a_ack}, 64'd1);
        @(posedge clk);
        #1 bus.input_a_stb = 1'b0;
    endtask

    // Counts edges after the accepting edge until output_z_stb is seen high.
    task automatic wait_z(output logic [63:0] z, output int lat);
        lat = 0;
        while (bus.output_z_stb !== 1'b1 && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 300) check("stb_timeout", {63'd0, bus.output_z_stb}, 64'd1);
        z = bus.output_z;
    endtask

    task automatic take(input int gap);
        @(negedge clk);
        repeat (gap) @(negedge clk);
        bus.output_z_ack = 1'b1;
        @(posedge clk);
        #1 bus.output_z_ack = 1'b0;
    endtask

    task automatic conv(input string tag, input logic [63:0] a,
                        input logic [63:0] expv, input int exp_lat);
        logic [63:0] z;
        int          lat;
        send(a, 0);
        wait_z(z, lat);
        check(tag, z, expv);
        check({tag, "_model"}, z, ref_model(a));
        if (exp_lat >= 0) check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        take(0);
    endtask

    initial begin
        logic [63:0] z, z0, x;
        int          lat, sh;
        logic        ok;

        bus.input_a      = '0;
        bus.input_a_stb  = 1'b0;
        bus.output_z_ack = 1'b0;
        rst = 1'b1;
        #2;
        check("rst_z",   bus.output_z, 64'd0);
        check("rst_stb", {63'd0, bus.output_z_stb}, 64'd0);
        check("rst_ack", {63'd0, bus.input_a_ack}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic values and extremes
        conv("one",     64'd1,                 64'h3FF0000000000000, 67);
        conv("neg_one", 64'hFFFFFFFFFFFFFFFF,  64'hBFF0000000000000, 67);
        conv("zero",    64'd0,                 64'h0000000000000000, 2);
        conv("min",     64'h8000000000000000,  64'hC3E0000000000000, 4);
        conv("max",     64'h7FFFFFFFFFFFFFFF,  64'h43E0000000000000, 5);

        // Ties around 2^53
        conv("tie_dn",  64'h0020000000000001,  64'h4340000000000000, -1);
        conv("tie_up",  64'h0020000000000003,  64'h4340000000000002, -1);
        conv("tie_ev",  64'h0020000000000005,  64'h4340000000000002, -1);
        conv("tie_neg", -64'h0020000000000003, 64'hC340000000000002, -1);

        // Back-pressure: result must hold with ack low
        send(64'd1000, 0);
        wait_z(z0, lat);
        check("bp_value", z0, 64'h408F400000000000);
        ok = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.output_z_stb !== 1'b1 || bus.output_z !== z0 || bus.input_a_ack !== 1'b0)
                ok = 1'b0;
        end
        check("bp_hold", {63'd0, ok}, 64'd1);
        @(negedge clk);
        bus.output_z_ack = 1'b1;
        @(posedge clk);
        #1 bus.output_z_ack = 1'b0;
        check("bp_stb_drop", {63'd0, bus.output_z_stb}, 64'd0);
        check("bp_ack_low",  {63'd0, bus.input_a_ack}, 64'd0);
        @(posedge clk);
        #1;
        check("bp_ack_back", {63'd0, bus.input_a_ack}, 64'd1);

        // Reset during normalise aborts the conversion
        send(64'd1, 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_z",   bus.output_z, 64'd0);
        check("mid_rst_stb", {63'd0, bus.output_z_stb}, 64'd0);
        check("mid_rst_ack", {63'd0, bus.input_a_ack}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ok = 1'b1;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (bus.output_z_stb !== 1'b0) ok = 1'b0;
        end
        check("no_stale", {63'd0, ok}, 64'd1);
        conv("after_rst", 64'd42, 64'h4045000000000000, 62);

        // Random stream with stb/ack gaps
        for (int i = 0; i < 1000; i++) begin
            x  = {$urandom, $urandom};
            sh = $urandom_range(0, 63);
            x  = x >> sh;
            if ($urandom_range(0, 1) == 1) x = -x;
            if ($urandom_range(0, 49) == 0) x = '0;
            send(x, $urandom_range(0, 3));
            wait_z(z, lat);
            check("stream", z, ref_model(x));
            take($urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
